// File: rtl/step_motor_sequencer.sv
// step_motor_sequencer: bipolar stepper phase sequencer with full/half-step moves, abort, coil hold and signed position count.
module step_motor_sequencer #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic             half_step,
  input  logic             hold,
  input  logic [CNT_W-1:0] steps,
  input  logic [CNT_W-1:0] period,
  input  logic             pos_clear,
  output logic             AX,
  output logic             AY,
  output logic             BX,
  output logic             BY,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state;
  logic [2:0]       r_idx;
  logic             r_dir;
  logic             r_half;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_reload;
  logic [3:0]       r_coils;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] w_eff;
  logic [2:0]       w_delta;
  logic [2:0]       w_idx_step;
  logic [2:0]       w_idx_d;
  logic             w_in_run;
  logic             w_start;
  logic             w_abort;
  logic             w_step;
  logic             w_finish;
  logic             w_run_d;
  function automatic logic [3:0] pattern(input logic [2:0] i);
    case (i)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1010;
      3'd2:    pattern = 4'b0010;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0100;
      3'd5:    pattern = 4'b0101;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  endfunction
  // Full-step from an even index takes a single-phase hop to reach the two-coil (odd) grid.
  always_comb begin
    w_eff      = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    w_delta    = (r_half || !r_idx[0]) ? 3'd1 : 3'd2;
    w_idx_step = r_dir ? r_idx + w_delta : r_idx - w_delta;
    w_in_run   = (r_state == RUN);
    w_start    = (r_state == IDLE) && start;
    w_abort    = w_in_run && abort;
    w_step     = w_in_run && !abort && (r_rem != '0) && (r_cnt == '0);
    w_finish   = w_in_run && !abort && ((r_rem == '0) || (w_step && r_rem == CNT_W'(1)));
    w_idx_d    = w_step ? w_idx_step : r_idx;
    w_run_d    = w_start || (w_in_run && !w_abort && !w_finish);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_dir     <= 1'b0;
      r_half    <= 1'b0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_reload  <= '0;
      r_coils   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_state <= w_run_d ? RUN : IDLE;
      r_busy  <= w_run_d;
      r_done  <= w_abort || w_finish;
      r_idx   <= w_idx_d;
      r_coils <= (w_run_d || hold) ? pattern(w_idx_d) : 4'b0000;
      if (w_start) begin
        r_dir     <= dir;
        r_half    <= half_step;
        r_rem     <= steps;
        r_cnt     <= w_eff - CNT_W'(1);
        r_reload  <= w_eff - CNT_W'(1);
        r_aborted <= 1'b0;
      end else if (w_step) begin
        r_rem <= r_rem - CNT_W'(1);
        r_cnt <= r_reload;
      end else if (w_in_run && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_abort)
        r_aborted <= 1'b1;
      if (pos_clear)
        r_pos <= '0;
      else if (w_step)
        r_pos <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
    end
  end
  assign {AX, AY, BX, BY} = r_coils;
  assign busy     = r_busy;
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign position = r_pos;
endmodule

// File: tb/tb_step_motor_sequencer.sv
// tb_step_motor_sequencer: directed moves with a scoreboard of expected end-of-move results.
module tb_step_motor_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir = 1'b0;
  logic        half_step = 1'b0;
  logic        hold = 1'b0;
  logic        pos_clear = 1'b0;
  logic [15:0] steps = '0;
  logic [15:0] period = '0;
  logic        AX, AY, BX, BY, busy, done, aborted;
  logic [31:0] position;
  logic        ax4, ay4, bx4, by4, busy4, done4, aborted4;
  logic [3:0]  pos4;
  logic [3:0]  coils;
  int          vec = 0;
  int          bad = 0;
  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] pos;
    logic [3:0]  coils;
    logic        ab;
  } exp_t;
  exp_t sb[$];
  logic [3:0] pat [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001, 4'b1001};

  step_motor_sequencer #(.CNT_W(16), .POS_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .dir(dir),
    .half_step(half_step), .hold(hold), .steps(steps), .period(period), .pos_clear(pos_clear),
    .AX(AX), .AY(AY), .BX(BX), .BY(BY), .busy(busy), .done(done), .aborted(aborted),
    .position(position)
  );
  step_motor_sequencer #(.CNT_W(16), .POS_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .dir(dir),
    .half_step(half_step), .hold(hold), .steps(steps), .period(period), .pos_clear(pos_clear),
    .AX(ax4), .AY(ay4), .BX(bx4), .BY(by4), .busy(busy4), .done(done4), .aborted(aborted4),
    .position(pos4)
  );

  assign coils = {AX, AY, BX, BY};
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk); #1 pos_clear = 1'b1;
    @(posedge clk); #1 pos_clear = 1'b0;
    chk("pos_clear", position, 32'h0);
  endtask

  // Cycle 0 is the start cycle; c counts cycles thereafter, sampled 1 time unit after each edge.
  task automatic move(input string tag, input bit d, input bit hs, input int n, input int per,
                      input int ecyc, input logic [31:0] epos, input logic [3:0] ecoils, input bit eab,
                      input int mid_cyc, input logic [3:0] mid_coils,
                      input int abort_at, input int busy_start_at, input int clr_at);
    exp_t e;
    int c;
    e.tag = tag; e.cyc = ecyc; e.pos = epos; e.coils = ecoils; e.ab = eab;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; dir = d; half_step = hs; steps = 16'(n); period = 16'(per);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && c < 2000) begin
      if (c == mid_cyc) chk({tag, "_mid"}, 32'(coils), 32'(mid_coils));
      abort = (c == abort_at);
      start = (c == busy_start_at);
      pos_clear = (c == clr_at);
      @(posedge clk); #1;
      c++;
    end
    abort = 1'b0; start = 1'b0; pos_clear = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_cycle"}, 32'(c), 32'(e.cyc));
    chk({e.tag, "_pos"}, position, e.pos);
    chk({e.tag, "_coils"}, 32'(coils), 32'(e.coils));
    chk({e.tag, "_aborted"}, 32'(aborted), 32'(e.ab));
    chk({e.tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_coils", 32'(coils), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pos", position, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("idle_abort_done", 32'(done), 32'h0);
    chk("idle_abort_flag", 32'(aborted), 32'h0);
    hold = 1'b1;
    move("half_fwd", 1, 1, 10, 4, 41, 32'd10, pat[2], 0, 5, pat[1], -1, -1, -1);
    clr();
    move("full_rev", 0, 0, 3, 2, 7, 32'hFFFF_FFFD, pat[5], 0, 3, pat[1], -1, -1, -1);
    clr();
    hold = 1'b0;
    move("abort", 1, 1, 100, 5, 24, 32'd4, 4'b0000, 1, 1, pat[5], 23, -1, -1);
    hold = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("hold_on", 32'(coils), 32'(pat[1]));
    move("period0", 1, 1, 2, 0, 5, 32'd6, pat[3], 0, 3, pat[2], -1, -1, -1);
    move("steps0", 1, 0, 0, 7, 2, 32'd6, pat[3], 0, -1, 4'b0, -1, -1, -1);
    move("busy_start", 1, 1, 3, 3, 10, 32'd9, pat[6], 0, 4, pat[4], -1, 2, -1);
    move("clr_step", 1, 1, 2, 3, 7, 32'd1, pat[0], 0, 4, pat[7], -1, -1, 3);
    clr();
    move("to_max4", 1, 1, 7, 2, 15, 32'd7, pat[7], 0, -1, 4'b0, -1, -1, -1);
    chk("pos4_max", 32'(pos4), 32'h7);
    move("wrap_fwd", 1, 1, 1, 2, 3, 32'd8, pat[0], 0, -1, 4'b0, -1, -1, -1);
    chk("pos4_wrap", 32'(pos4), 32'h8);
    clr();
    move("wrap_rev", 0, 1, 1, 2, 3, 32'hFFFF_FFFF, pat[7], 0, -1, 4'b0, -1, -1, -1);
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b1; half_step = 1'b1; steps = 16'd100; period = 16'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("amid_rst_coils", 32'(coils), 32'h0);
    chk("amid_rst_busy", 32'(busy), 32'h0);
    chk("amid_rst_done", 32'(done), 32'h0);
    chk("amid_rst_pos", position, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
